// File: rtl/tiny_dnn_conv_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : tiny_dnn_conv_seq_if
// Brief    : Source-address stream between the conv sequencer and datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface tiny_dnn_conv_seq_if #(
    parameter int AW = 12
);
    logic          src_valid;
    logic          src_ready;
    logic [AW-1:0] src_addr;
    logic          acc_last;
    logic          frame_last;

    modport master (
        output src_valid,
        output src_addr,
        output acc_last,
        output frame_last,
        input  src_ready
    );

    modport slave (
        input  src_valid,
        input  src_addr,
        input  acc_last,
        input  frame_last,
        output src_ready
    );
endinterface
`default_nettype wire

// File: rtl/tiny_dnn_conv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tiny_dnn_conv_seq
// Brief    : Walks one conv/pool pass (oy,ox,c,ky,kx) emitting source addresses.
// Revision : 1.0 - initial release
// ============================================================================
module tiny_dnn_conv_seq #(
    parameter int AW = 12
) (
    input  wire logic        S_AXI_ACLK,
    input  wire logic        S_AXI_ARESETN,
    input  wire logic        run,
    input  wire logic [4:0]  kw,
    input  wire logic [4:0]  kh,
    input  wire logic [3:0]  id,
    input  wire logic [4:0]  iw,
    input  wire logic [9:0]  is,
    input  wire logic [4:0]  ow,
    input  wire logic [4:0]  oh,
    tiny_dnn_conv_seq_if.master src,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_RUN  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]    r_state, w_state_nx;
    logic          r_run_q;
    logic          r_src_valid, r_acc_last, r_frame_last, r_busy, r_done;
    logic          w_src_valid_nx, w_busy_nx, w_done_nx;
    logic          w_acc_nx, w_frame_nx;
    logic          w_start, w_fire, w_zero_cfg;

    logic [4:0]    r_kw, r_kh, r_iw, r_ow, r_oh;
    logic [3:0]    r_id;
    logic [9:0]    r_is;

    logic [4:0]    r_kx, r_ky, r_ox, r_oy, w_kx_nx, w_ky_nx, w_ox_nx, w_oy_nx;
    logic [3:0]    r_c, w_c_nx;
    logic [AW-1:0] r_prow, r_pix, r_row, r_chan, r_addr;
    logic [AW-1:0] w_prow_nx, w_pix_nx, w_row_nx, w_chan_nx, w_addr_nx;
    logic [AW-1:0] w_iw_ext, w_is_ext;

    assign w_start    = run & ~r_run_q;
    assign w_fire     = r_src_valid & src.src_ready;
    assign w_zero_cfg = (kw == 5'd0) || (kh == 5'd0) || (id == 4'd0) ||
                        (ow == 5'd0) || (oh == 5'd0);
    assign w_iw_ext   = {{(AW-5){1'b0}}, r_iw};
    assign w_is_ext   = {{(AW-10){1'b0}}, r_is};

    // State register
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic; a low run level aborts without a done pulse
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_IDLE: if (w_start) w_state_nx = c_LOAD;
            c_LOAD: begin
                if (!run)            w_state_nx = c_IDLE;
                else if (w_zero_cfg) w_state_nx = c_DONE;
                else                 w_state_nx = c_RUN;
            end
            c_RUN: begin
                if (!run)                        w_state_nx = c_IDLE;
                else if (w_fire && r_frame_last) w_state_nx = c_DONE;
            end
            default: w_state_nx = c_IDLE;
        endcase
    end

    // Output logic: next values of the registered status outputs
    always_comb begin
        w_src_valid_nx = (w_state_nx == c_RUN);
        w_busy_nx      = (w_state_nx != c_IDLE);
        w_done_nx      = (w_state_nx == c_DONE);
    end

    // Counter/address stepping; addresses advance by adds only
    always_comb begin
        w_kx_nx   = r_kx;
        w_ky_nx   = r_ky;
        w_c_nx    = r_c;
        w_ox_nx   = r_ox;
        w_oy_nx   = r_oy;
        w_prow_nx = r_prow;
        w_pix_nx  = r_pix;
        w_row_nx  = r_row;
        w_chan_nx = r_chan;
        w_addr_nx = r_addr;
        w_acc_nx  = r_acc_last;
        w_frame_nx = r_frame_last;
        if (r_state == c_LOAD) begin
            w_kx_nx   = '0;
            w_ky_nx   = '0;
            w_c_nx    = '0;
            w_ox_nx   = '0;
            w_oy_nx   = '0;
            w_prow_nx = '0;
            w_pix_nx  = '0;
            w_row_nx  = '0;
            w_chan_nx = '0;
            w_addr_nx = '0;
            w_acc_nx   = (kw == 5'd1) && (kh == 5'd1) && (id == 4'd1);
            w_frame_nx = w_acc_nx && (ow == 5'd1) && (oh == 5'd1);
        end else if (r_state == c_RUN && w_fire) begin
            if (r_kx != r_kw - 5'd1) begin
                w_kx_nx   = r_kx + 5'd1;
                w_addr_nx = r_addr + AW'(1);
            end else begin
                w_kx_nx = '0;
                if (r_ky != r_kh - 5'd1) begin
                    w_ky_nx   = r_ky + 5'd1;
                    w_row_nx  = r_row + w_iw_ext;
                    w_addr_nx = r_chan + r_row + w_iw_ext;
                end else begin
                    w_ky_nx  = '0;
                    w_row_nx = r_pix;
                    if (r_c != r_id - 4'd1) begin
                        w_c_nx    = r_c + 4'd1;
                        w_chan_nx = r_chan + w_is_ext;
                        w_addr_nx = r_chan + w_is_ext + r_pix;
                    end else begin
                        w_c_nx    = '0;
                        w_chan_nx = '0;
                        if (r_ox != r_ow - 5'd1) begin
                            w_ox_nx   = r_ox + 5'd1;
                            w_pix_nx  = r_pix + AW'(1);
                            w_row_nx  = r_pix + AW'(1);
                            w_addr_nx = r_pix + AW'(1);
                        end else begin
                            w_ox_nx   = '0;
                            w_oy_nx   = (r_oy != r_oh - 5'd1) ? r_oy + 5'd1 : 5'd0;
                            w_prow_nx = r_prow + w_iw_ext;
                            w_pix_nx  = r_prow + w_iw_ext;
                            w_row_nx  = r_prow + w_iw_ext;
                            w_addr_nx = r_prow + w_iw_ext;
                        end
                    end
                end
            end
            w_acc_nx   = (w_kx_nx == r_kw - 5'd1) && (w_ky_nx == r_kh - 5'd1) &&
                         (w_c_nx == r_id - 4'd1);
            w_frame_nx = w_acc_nx && (w_ox_nx == r_ow - 5'd1) && (w_oy_nx == r_oh - 5'd1);
        end
    end

    // Datapath and output registers; run_q resets high so a level held through reset is no edge
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_run_q      <= 1'b1;
            r_src_valid  <= 1'b0;
            r_acc_last   <= 1'b0;
            r_frame_last <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_kw <= '0; r_kh <= '0; r_id <= '0; r_iw <= '0;
            r_is <= '0; r_ow <= '0; r_oh <= '0;
            r_kx <= '0; r_ky <= '0; r_c <= '0; r_ox <= '0; r_oy <= '0;
            r_prow <= '0; r_pix <= '0; r_row <= '0; r_chan <= '0; r_addr <= '0;
        end else begin
            r_run_q      <= run;
            r_src_valid  <= w_src_valid_nx;
            r_acc_last   <= w_acc_nx & w_src_valid_nx;
            r_frame_last <= w_frame_nx & w_src_valid_nx;
            r_busy       <= w_busy_nx;
            r_done       <= w_done_nx;
            if (r_state == c_LOAD) begin
                r_kw <= kw; r_kh <= kh; r_id <= id; r_iw <= iw;
                r_is <= is; r_ow <= ow; r_oh <= oh;
            end
            r_kx <= w_kx_nx; r_ky <= w_ky_nx; r_c <= w_c_nx;
            r_ox <= w_ox_nx; r_oy <= w_oy_nx;
            r_prow <= w_prow_nx; r_pix <= w_pix_nx; r_row <= w_row_nx;
            r_chan <= w_chan_nx; r_addr <= w_addr_nx;
        end
    end

    assign src.src_valid  = r_src_valid;
    assign src.src_addr   = r_addr;
    assign src.acc_last   = r_acc_last;
    assign src.frame_last = r_frame_last;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tiny_dnn_conv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tiny_dnn_conv_seq
// Brief    : Randomized bench for tiny_dnn_conv_seq against a nested-loop model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tiny_dnn_conv_seq;

    localparam int AW = 12;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [4:0] kw, kh, iw, ow, oh;
    logic [3:0] id;
    logic [9:0] is;
    logic       busy, done;
    int         n_checks;
    int         n_errors;

    tiny_dnn_conv_seq_if #(.AW(AW)) ifc ();

    tiny_dnn_conv_seq #(.AW(AW)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .run           (run),
        .kw            (kw),
        .kh            (kh),
        .id            (id),
        .iw            (iw),
        .is            (is),
        .ow            (ow),
        .oh            (oh),
        .src           (ifc),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [13:0] observed();
        return {ifc.frame_last, ifc.acc_last, ifc.src_addr};
    endfunction

    // One pass: reference beats built from the addressing formula, then compared in order.
    task automatic run_pass(input int t_kw, input int t_kh, input int t_id, input int t_iw,
                            input int t_is, input int t_ow, input int t_oh,
                            input int rdy_pct, input int abort_at);
        logic [13:0] exp_q[$];
        logic [13:0] held, e;
        int total, beats, first_cyc, last_hs, done_cyc, done_cnt, budget;
        bit stall, finished;
        total = t_kw * t_kh * t_id * t_ow * t_oh;
        for (int oy = 0; oy < t_oh; oy++)
            for (int ox = 0; ox < t_ow; ox++)
                for (int c = 0; c < t_id; c++)
                    for (int ky = 0; ky < t_kh; ky++)
                        for (int kx = 0; kx < t_kw; kx++) begin
                            int a;
                            bit al, fl;
                            a  = (c * t_is + (oy + ky) * t_iw + ox + kx) % (1 << AW);
                            al = (c == t_id - 1) && (ky == t_kh - 1) && (kx == t_kw - 1);
                            fl = al && (oy == t_oh - 1) && (ox == t_ow - 1);
                            exp_q.push_back({fl, al, a[AW-1:0]});
                        end
        kw = t_kw[4:0]; kh = t_kh[4:0]; id = t_id[3:0]; iw = t_iw[4:0];
        is = t_is[9:0]; ow = t_ow[4:0]; oh = t_oh[4:0];
        run = 1'b0;
        ifc.src_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        run = 1'b1;
        ifc.src_ready = ($urandom_range(99) < rdy_pct);
        budget = total * 30 + 40;
        first_cyc = -1; last_hs = -1; done_cyc = -1; done_cnt = 0; beats = 0;
        stall = 1'b0; finished = 1'b0; held = '0;
        for (int cyc = 0; cyc < budget && !finished; cyc++) begin
            @(negedge clk);
            if (stall) begin
                check("stall_valid", {31'd0, ifc.src_valid}, 32'd1);
                check("stall_hold", {18'd0, observed()}, {18'd0, held});
            end
            if (ifc.src_valid && first_cyc < 0) first_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check("busy_after_done", {31'd0, busy}, 32'd0);
                check("done_one_cycle", {31'd0, done}, 32'd0);
                finished = 1'b1;
            end
            if (ifc.src_valid && ifc.src_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {18'd0, observed()}, {18'd0, e});
                end
                beats++;
                last_hs = cyc;
                if (beats == 1) begin
                    kw = 5'($urandom); kh = 5'($urandom); id = 4'($urandom);
                    iw = 5'($urandom); is = 10'($urandom); ow = 5'($urandom);
                end
                if (abort_at >= 0 && beats == abort_at) begin
                    @(posedge clk); #1;
                    run = 1'b0;
                    ifc.src_ready = 1'b0;
                    @(negedge clk);
                    @(negedge clk);
                    check("abort_valid", {31'd0, ifc.src_valid}, 32'd0);
                    check("abort_busy", {31'd0, busy}, 32'd0);
                    done_cnt = 0;
                    repeat (4) begin
                        @(negedge clk);
                        if (done) done_cnt++;
                    end
                    check("abort_no_done", done_cnt, 32'd0);
                    return;
                end
            end
            stall = ifc.src_valid && !ifc.src_ready;
            held  = observed();
            @(posedge clk); #1;
            ifc.src_ready = ($urandom_range(99) < rdy_pct);
        end
        if (!finished) check("timeout", 32'd0, 32'd1);
        check("beat_count", beats, total);
        check("first_valid_cyc", first_cyc, (total > 0) ? 2 : -1);
        check("done_count", done_cnt, 32'd1);
        check("done_latency", done_cyc, (total > 0) ? last_hs + 1 : 2);
        run = 1'b0;
        ifc.src_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        run = 1'b0;
        ifc.src_ready = 1'b0;
        kw = 5'd2; kh = 5'd2; id = 4'd1; iw = 5'd4; is = 10'd16; ow = 5'd3; oh = 5'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, ifc.src_valid}, 32'd0);
        check("rst_addr", {20'd0, ifc.src_addr}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_lasts", {30'd0, ifc.acc_last, ifc.frame_last}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_pass(2, 2, 1, 4, 16, 3, 3, 100, -1);
        run_pass(2, 2, 2, 4, 16, 3, 3, 100, -1);
        run_pass(2, 2, 1, 4, 16, 3, 3, 50, -1);
        run_pass(2, 0, 1, 4, 16, 3, 3, 100, -1);
        run_pass(2, 2, 1, 4, 16, 3, 3, 100, 10);
        run_pass(2, 2, 1, 4, 16, 3, 3, 100, -1);
        run_pass(1, 1, 4, 31, 1000, 2, 2, 70, -1);
        run_pass(1, 1, 1, 7, 3, 1, 1, 100, -1);

        // Asynchronous reset in the middle of a pass, run held high across release
        kw = 5'd2; kh = 5'd2; id = 4'd1; iw = 5'd4; is = 10'd16; ow = 5'd3; oh = 5'd3;
        @(posedge clk); #1;
        run = 1'b1;
        ifc.src_ready = 1'b1;
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, ifc.src_valid}, 32'd0);
        check("async_rst_addr", {20'd0, ifc.src_addr}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("no_restart", {30'd0, ifc.src_valid, busy}, 32'd0);
        end
        run = 1'b0;
        ifc.src_ready = 1'b0;
        run_pass(2, 2, 1, 4, 16, 3, 3, 100, -1);

        for (int r = 0; r < 4; r++) begin
            run_pass($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
                     $urandom_range(1, 31), $urandom_range(0, 1023),
                     $urandom_range(1, 3), $urandom_range(1, 3),
                     $urandom_range(30, 100), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
